// File: rtl/stopwatch_core.sv
// MM:SS stopwatch core: synchronized divider levels, PAUSED/RUN/ADJUST control and BCD time.
// Define ADJ_BLINK_EN to blink the selected field's digits while adjusting.
module stopwatch_core #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lvl_1hz,
  input  logic       lvl_2hz,
  input  logic       lvl_blink,
  input  logic       pause_p,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] blank,
  output logic       running
);

  typedef enum logic [1:0] {StPaused, StRun, StAdjust} state_e;

  state_e state_q, state_d, ret_q, ret_d;

  logic [SYNC_STAGES-1:0] s1_q, s2_q;
  logic                   h1_q, h2_q;
  logic                   tick1, tick2;
  logic [7:0]             min_q, min_d, sec_q, sec_d;
  logic                   running_d;
  logic [3:0]             blank_q, blank_d;

  // Increment a packed BCD {tens, ones} field modulo 60.
  function automatic logic [7:0] inc60(input logic [7:0] f);
    logic [7:0] r;
    r = f;
    if (f[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (f[7:4] == 4'd5) ? 4'd0 : f[7:4] + 4'd1;
    end else begin
      r[3:0] = f[3:0] + 4'd1;
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= '0;
      s2_q <= '0;
      h1_q <= 1'b0;
      h2_q <= 1'b0;
    end else begin
      s1_q <= {s1_q[SYNC_STAGES-2:0], lvl_1hz};
      s2_q <= {s2_q[SYNC_STAGES-2:0], lvl_2hz};
      h1_q <= s1_q[SYNC_STAGES-1];
      h2_q <= s2_q[SYNC_STAGES-1];
    end
  end

  assign tick1 = s1_q[SYNC_STAGES-1] & ~h1_q;
  assign tick2 = s2_q[SYNC_STAGES-1] & ~h2_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StPaused;
      ret_q   <= StPaused;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
    end
  end

  // Next state: adj wins over pause_p; ADJUST returns to the state held at entry.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    case (state_q)
      StPaused: begin
        if (adj) begin
          state_d = StAdjust;
          ret_d   = StPaused;
        end else if (pause_p) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (adj) begin
          state_d = StAdjust;
          ret_d   = StRun;
        end else if (pause_p) begin
          state_d = StPaused;
        end
      end
      StAdjust: begin
        if (!adj) state_d = ret_q;
      end
      default: state_d = StPaused;
    endcase
  end

  // Time update: full carry in RUN, per-field modulo-60 with no carry in ADJUST.
  always_comb begin
    min_d = min_q;
    sec_d = sec_q;
    if (state_q == StRun && !adj && tick1) begin
      sec_d = inc60(sec_q);
      if (sec_q == 8'h59) min_d = inc60(min_q);
    end else if (state_q == StAdjust && tick2) begin
      if (sel) sec_d = inc60(sec_q);
      else     min_d = inc60(min_q);
    end
  end

`ifdef ADJ_BLINK_EN
  logic [SYNC_STAGES-1:0] sb_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sb_q <= '0;
    else      sb_q <= {sb_q[SYNC_STAGES-2:0], lvl_blink};
  end
`else
  logic unused_blink;
  assign unused_blink = lvl_blink;
`endif

  // Output decode from the next state so the registered flags line up with state_q.
  always_comb begin
    running_d = (state_d == StRun);
    blank_d   = 4'b0000;
`ifdef ADJ_BLINK_EN
    if (state_d == StAdjust && sb_q[SYNC_STAGES-1]) blank_d = sel ? 4'b0011 : 4'b1100;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      min_q   <= 8'h00;
      sec_q   <= 8'h00;
      running <= 1'b0;
      blank_q <= 4'b0000;
    end else begin
      min_q   <= min_d;
      sec_q   <= sec_d;
      running <= running_d;
      blank_q <= blank_d;
    end
  end

  assign min_tens = min_q[7:4];
  assign min_ones = min_q[3:0];
  assign sec_tens = sec_q[7:4];
  assign sec_ones = sec_q[3:0];
  assign blank    = blank_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core: directed scenarios plus randomized levels and pulses,
// compared every cycle against a seconds-and-mode reference model.
module tb_stopwatch_core;
  localparam int unsigned S = 2;
  localparam int MPaused = 0, MRun = 1, MAdj = 2;

  logic clk = 1'b0, rst = 1'b0;
  logic l1 = 1'b0, l2 = 1'b0, lb = 1'b0, pp = 1'b0, ad = 1'b0, sl = 1'b0;
  logic [3:0] mt, mo, st, so, blank;
  logic running;

  always #5 clk = ~clk;

  stopwatch_core #(.SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .lvl_1hz(l1), .lvl_2hz(l2), .lvl_blink(lb),
    .pause_p(pp), .adj(ad), .sel(sl),
    .min_tens(mt), .min_ones(mo), .sec_tens(st), .sec_ones(so),
    .blank(blank), .running(running)
  );

  int n_vec = 0, n_err = 0;

  // Reference model: minutes/seconds as integers, mode, and a sample history per level input.
  int m_mode, m_ret, m_min, m_sec;
  bit m_run;
  logic [3:0] m_blank;
  bit q1[$], q2[$], qb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] digits();
    return {mt, mo, st, so};
  endfunction

  task automatic m_reset();
    m_mode = MPaused; m_ret = MPaused; m_min = 0; m_sec = 0;
    m_run = 1'b0; m_blank = 4'b0000;
    q1 = {}; q2 = {}; qb = {};
    repeat (S + 1) begin q1.push_back(1'b0); q2.push_back(1'b0); qb.push_back(1'b0); end
  endtask

  // A rise is seen S+1 edges after first sampled: sample[k-S+1] high while sample[k-S] low.
  task automatic m_edge();
    bit t1, t2, bl;
    int nm;
    t1 = q1[S-1] && !q1[S];
    t2 = q2[S-1] && !q2[S];
    bl = qb[S-1];
    nm = m_mode;
    case (m_mode)
      MPaused: begin
        if (ad) begin m_ret = MPaused; nm = MAdj; end
        else if (pp) nm = MRun;
      end
      MRun: begin
        if (ad) begin m_ret = MRun; nm = MAdj; end
        else begin
          if (t1) begin
            m_sec++;
            if (m_sec == 60) begin m_sec = 0; m_min = (m_min + 1) % 60; end
          end
          if (pp) nm = MPaused;
        end
      end
      default: begin
        if (t2) begin
          if (sl) m_sec = (m_sec + 1) % 60;
          else    m_min = (m_min + 1) % 60;
        end
        if (!ad) nm = m_ret;
      end
    endcase
    m_mode = nm;
    m_run  = (nm == MRun);
`ifdef ADJ_BLINK_EN
    m_blank = (nm == MAdj && bl) ? (sl ? 4'b0011 : 4'b1100) : 4'b0000;
`else
    m_blank = 4'b0000;
`endif
    q1.push_front(l1); void'(q1.pop_back());
    q2.push_front(l2); void'(q2.pop_back());
    qb.push_front(lb); void'(qb.pop_back());
  endtask

  task automatic compare();
    logic [15:0] e;
    bit legal;
    e = {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
    legal = (mt <= 4'd5) && (mo <= 4'd9) && (st <= 4'd5) && (so <= 4'd9);
    check("digits", 32'(digits()), 32'(e));
    check("running", 32'(running), 32'(m_run));
    check("blank", 32'(blank), 32'(m_blank));
    check("bcd_legal", 32'(legal), 32'd1);
  endtask

  // Inputs change only at posedge+1; pause_p is cleared after each edge so it stays one cycle.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      if (rst) m_edge();
      #1;
      compare();
      pp = 1'b0;
    end
  endtask

  task automatic pulse(input int which);
    if (which == 1) l1 = 1'b1; else l2 = 1'b1;
    step(3);
    if (which == 1) l1 = 1'b0; else l2 = 1'b0;
    step(3);
  endtask

  int c1 = 3, c2 = 2, cb = 5;
  logic [3:0] exp_bl;

  initial begin
    m_reset();
    step(2);
    check("reset_digits", 32'(digits()), 32'h0000);
    check("reset_running", 32'(running), 32'd0);
    rst = 1'b1;
    step(2);

    // Run, three 1 Hz rises; third update lands on the third edge after the rise.
    pp = 1'b1; step(1);
    pulse(1); pulse(1);
    l1 = 1'b1; step(2);
    check("rise_pre", 32'(digits()), 32'h0002);
    step(1);
    check("rise_3rd_edge", 32'(digits()), 32'h0003);
    check("rise_running", 32'(running), 32'd1);
    l1 = 1'b0; step(3);

    // Preload 59:59 via adjust, run, one tick -> 00:00.
    pp = 1'b1; step(1);
    ad = 1'b1; sl = 1'b0; step(1);
    repeat (59) pulse(2);
    sl = 1'b1;
    repeat (56) pulse(2);
    check("preload", 32'(digits()), 32'h5959);
    ad = 1'b0; step(1);
    check("adj_ret_paused", 32'(running), 32'd0);
    pp = 1'b1; step(1);
    pulse(1);
    check("wrap", 32'(digits()), 32'h0000);

    // Seconds adjust wraps without touching minutes; 1 Hz ignored; RUN restored.
    ad = 1'b1; sl = 1'b1; step(1);
    repeat (58) pulse(2);
    check("adj_58", 32'(digits()), 32'h0058);
    pulse(1); pulse(1);
    check("adj_ignore_1hz", 32'(digits()), 32'h0058);
    pulse(2); pulse(2);
    check("adj_sec_wrap", 32'(digits()), 32'h0000);
    ad = 1'b0; step(1);
    check("adj_ret_run", 32'(running), 32'd1);

    // pause_p coincident with tick1 at 00:10.
    ad = 1'b1; step(1);
    repeat (10) pulse(2);
    ad = 1'b0; step(1);
    check("at_10", 32'(digits()), 32'h0010);
    l1 = 1'b1; step(2);
    pp = 1'b1; step(1);
    check("coinc_count", 32'(digits()), 32'h0011);
    check("coinc_paused", 32'(running), 32'd0);
    l1 = 1'b0; step(3);
    pulse(1);
    check("paused_hold", 32'(digits()), 32'h0011);

    // Asynchronous reset at 12:34 while running, 1 Hz held high through release.
    ad = 1'b1; sl = 1'b0; step(1);
    repeat (12) pulse(2);
    sl = 1'b1;
    repeat (23) pulse(2);
    ad = 1'b0; step(1);
    pp = 1'b1; step(1);
    check("at_1234", 32'(digits()), 32'h1234);
    l1 = 1'b1; step(1);
    #2 rst = 1'b0;
    #1 m_reset();
    check("async_digits", 32'(digits()), 32'h0000);
    check("async_running", 32'(running), 32'd0);
    check("async_blank", 32'(blank), 32'd0);
    step(2);
    rst = 1'b1;
    step(6);
    pp = 1'b1; step(1);
    step(6);
    check("release_no_count", 32'(digits()), 32'h0000);
    check("release_running", 32'(running), 32'd1);
    l1 = 1'b0; step(3);

    // Blink in minutes adjust.
    ad = 1'b1; sl = 1'b0; step(1);
    repeat (6) begin
      lb = ~lb; step(4);
`ifdef ADJ_BLINK_EN
      exp_bl = lb ? 4'b1100 : 4'b0000;
`else
      exp_bl = 4'b0000;
`endif
      check("blink", 32'(blank), 32'(exp_bl));
    end
    lb = 1'b0; ad = 1'b0; step(4);

    // Randomized phase.
    repeat (3000) begin
      c1 = c1 - 1; if (c1 == 0) begin l1 = ~l1; c1 = $urandom_range(2, 7); end
      c2 = c2 - 1; if (c2 == 0) begin l2 = ~l2; c2 = $urandom_range(1, 5); end
      cb = cb - 1; if (cb == 0) begin lb = ~lb; cb = $urandom_range(1, 6); end
      pp = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 59) == 0) ad = ~ad;
      if ($urandom_range(0, 29) == 0) sl = ~sl;
      step(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of synchronizer flops per level input (legal 2..4).
REQ-002 SHALL have port `clk`, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port `rst`, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port `lvl_1hz`, input, 1 bit: 1 Hz square wave from the divider; the count source.
REQ-005 SHALL have port `lvl_2hz`, input, 1 bit: 2 Hz square wave from the divider; the adjust-increment source.
REQ-006 SHALL have port `lvl_blink`, input, 1 bit: blink square wave from the divider.
REQ-007 SHALL have port `pause_p`, input, 1 bit: debounced, single-cycle pause-toggle pulse.
REQ-008 SHALL have port `adj`, input, 1 bit: adjust-mode level.
REQ-009 SHALL have port `sel`, input, 1 bit: adjust field select, 0 = minutes, 1 = seconds.
REQ-010 SHALL have ports `min_tens`, `min_ones`, `sec_tens`, `sec_ones`, output, 4 bits each: BCD time digits.
REQ-011 SHALL have port `blank`, output, 4 bits: per-digit blank request, with bit3 = min_tens ... bit0 = sec_ones.
REQ-012 SHALL have port `running`, output, 1 bit: high exactly when the state is RUN.

Function
REQ-013 SHALL pass each lvl_* input through a SYNC_STAGES-flop synchronizer followed by one history flop.
REQ-014 SHALL form one-cycle strobes tick1/tick2/… from synchronized-high AND history-low (rising edge only).
REQ-015 SHALL make counter outputs change on the (SYNC_STAGES+1)th clk rising edge after the input rise is first sampled.
REQ-016 SHALL implement states PAUSED, RUN and ADJUST.
REQ-017 SHALL transition PAUSED<->RUN on pause_p.
REQ-018 SHALL enter ADJUST from either state while adj=1, and on adj=0 return to the state held at entry.
REQ-019 SHALL ignore pause_p while in ADJUST, without queuing it.
REQ-020 SHALL, in RUN, increment MM:SS by one second on each tick1: sec_ones 9->0 carries to sec_tens, sec_tens 5->0 carries to min_ones, min_ones 9->0 carries to min_tens.
REQ-021 SHALL wrap 59:59 -> 00:00, holding no overflow flag.
REQ-022 SHALL, in PAUSED, ignore tick1 and tick2.
REQ-023 SHALL, in ADJUST, ignore tick1 and, on each tick2, increment the selected field by 1 modulo 60, with no carry into the other field (sec 59->00 leaves minutes unchanged).
REQ-024 SHALL apply a tick1 coincident with pause_p in RUN first, then enter PAUSED.
REQ-025 SHALL give ADJUST priority when adj rises in the same cycle as tick1: no count occurs.
REQ-026 SHALL keep every BCD digit within its legal range at all times (tens 0..5, ones 0..9).
REQ-027 SHALL register all outputs, with no combinational path from any input to any output.

Reset
REQ-028 SHALL, on rst low (asynchronously), set all digits to 0, blank to 4'b0000, state to PAUSED, running to 0, and all synchronizer and history flops to 0.
REQ-029 SHALL release reset on the first clk edge with rst high, and SHALL not generate a strobe on that edge even if lvl_* is already high: the history flop is also 0, so the first rise counts only after the synchronizer fills.
REQ-030 SHALL, on reset mid-ADJUST or mid-carry, discard the partial update and leave the block in PAUSED at 00:00.

Configuration
REQ-031 SHALL, with macro ADJ_BLINK_EN defined, drive the two blank bits of the selected field to the synchronized lvl_blink in ADJUST, and to 0 otherwise.
REQ-032 SHALL, without ADJ_BLINK_EN, hold blank constant 4'b0000, leave lvl_blink unused (port retained), and omit its synchronizer.

Verification
REQ-033 SHALL cover: reset, pause_p, then 3 rising edges on lvl_1hz -> digits 00:03 and running=1, each update on the 3rd clk edge after the input rise (SYNC_STAGES=2).
REQ-034 SHALL cover: preload 59:59 via adjust, run, one tick1 -> 00:00, with no intermediate illegal BCD value.
REQ-035 SHALL cover: adj=1, sel=1 at 00:58, two lvl_2hz rises -> 00:00 (minutes unchanged), lvl_1hz edges ignored; adj=0 -> previous state restored.
REQ-036 SHALL cover: pause_p coincident with tick1 at 00:10 in RUN -> 00:11, state PAUSED; a further tick1 leaves 00:11.
REQ-037 SHALL cover: rst low mid-count at 12:34 asynchronously -> all outputs 0 within the same cycle; lvl_1hz held high through release -> no count.
REQ-038 SHALL cover: with ADJ_BLINK_EN, ADJUST sel=0 and lvl_blink toggling -> blank toggles 4'b1100/4'b0000; without ADJ_BLINK_EN -> blank stays 4'b0000.
